// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Brief    : Shared operation encoding and sizing constants for the
//            pipelined carry-lookahead adder.
// Revision : 1.0
// ============================================================================
package cla_pkg;

   typedef enum logic {
      CLA_ADD = 1'b0,
      CLA_SUB = 1'b1
   } cla_op_e;

   localparam int CLA_DEF_WIDTH = 16;
   localparam int CLA_DEF_GROUP = 4;
   localparam int CLA_MAX_GROUP = 8;

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
// Module   : cla_group
// Brief    : Combinational GROUP-bit carry-lookahead slice (a, b, ci -> s, co).
// Revision : 1.0
// ============================================================================
module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = CLA_DEF_GROUP
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             ci,
   output logic [GROUP-1:0] s,
   output logic             co
);

   generate
      if ((GROUP < 1) || (GROUP > CLA_MAX_GROUP)) begin : g_bad_group
         $error("cla_group: GROUP out of range");
      end
   endgenerate

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP:0]   c;
   logic             run_p;
   logic             term;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is the flat sum-of-products g[j] & p[i..j+1], never a ripple.
   always_comb begin
      c     = '0;
      run_p = 1'b0;
      term  = 1'b0;
      c[0]  = ci;
      for (int i = 0; i < GROUP; i++) begin
         run_p = 1'b1;
         term  = 1'b0;
         for (int j = i; j >= 0; j--) begin
            term  = term | (run_p & g[j]);
            run_p = run_p & p[j];
         end
         c[i+1] = term | (run_p & ci);
      end
   end

   assign s  = p ^ c[GROUP-1:0];
   assign co = c[GROUP];

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder
// Brief    : Valid/ready pipelined adder/subtractor, one lookahead group per
//            stage; latency WIDTH/GROUP cycles, one result per cycle.
// Revision : 1.0
// ============================================================================
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_DEF_WIDTH,
   parameter int GROUP = CLA_DEF_GROUP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NGRP = WIDTH / GROUP;

   generate
      if ((GROUP < 1) || (GROUP > CLA_MAX_GROUP) || (WIDTH < GROUP) ||
          ((WIDTH % GROUP) != 0)) begin : g_bad_params
         $error("cla_pipe_adder: illegal WIDTH/GROUP combination");
      end
   endgenerate

   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;
   logic             ovf_d, ovf_q;
   logic             zero_d, zero_q;
   logic             advance;
   logic             msb_ci;

   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   // Stage k holds a word whose low slice is operand-a slice k and whose upper
   // slices are the sum slices already produced, rotated so that after the last
   // stage the word is the finished sum in natural bit order. The b remainder
   // shrinks by GROUP bits per stage.
   generate
      for (genvar k = 0; k < NGRP; k++) begin : g_stage
         localparam int RW = WIDTH - k * GROUP;

         logic             v_d, v_q;
         logic [WIDTH-1:0] acc_d, acc_q;
         logic [RW-1:0]    brem_d, brem_q;
         logic             c_d, c_q;
         logic [GROUP-1:0] s;
         logic             co;
         logic [WIDTH-1:0] acc_nxt;

         cla_group #(
            .GROUP (GROUP)
         ) u_grp (
            .a  (acc_q[GROUP-1:0]),
            .b  (brem_q[GROUP-1:0]),
            .ci (c_q),
            .s  (s),
            .co (co)
         );

         if (NGRP > 1) begin : g_rot
            assign acc_nxt = {s, acc_q[WIDTH-1:GROUP]};
         end else begin : g_norot
            assign acc_nxt = s;
         end

         if (k == 0) begin : g_head
            always_comb begin
               v_d    = v_q;
               acc_d  = acc_q;
               brem_d = brem_q;
               c_d    = c_q;
               if (advance) begin
                  v_d    = in_valid;
                  acc_d  = a;
                  brem_d = (op == CLA_SUB) ? ~b : b;
                  c_d    = (op == CLA_SUB) ? 1'b1 : cin;
               end
            end
         end else begin : g_body
            always_comb begin
               v_d    = v_q;
               acc_d  = acc_q;
               brem_d = brem_q;
               c_d    = c_q;
               if (advance) begin
                  v_d    = g_stage[k-1].v_q;
                  acc_d  = g_stage[k-1].acc_nxt;
                  brem_d = g_stage[k-1].brem_q[RW+GROUP-1:GROUP];
                  c_d    = g_stage[k-1].co;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_q    <= 1'b0;
               acc_q  <= '0;
               brem_q <= '0;
               c_q    <= 1'b0;
            end else begin
               v_q    <= v_d;
               acc_q  <= acc_d;
               brem_q <= brem_d;
               c_q    <= c_d;
            end
         end
      end
   endgenerate

   // Carry into the MSB recovered from the top sum bit and its effective operands.
   assign msb_ci = g_stage[NGRP-1].s[GROUP-1] ^ g_stage[NGRP-1].acc_q[GROUP-1] ^
                   g_stage[NGRP-1].brem_q[GROUP-1];

   always_comb begin
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      if (advance) begin
         out_valid_d = g_stage[NGRP-1].v_q;
         sum_d       = g_stage[NGRP-1].acc_nxt;
         cout_d      = g_stage[NGRP-1].co;
         ovf_d       = msb_ci ^ g_stage[NGRP-1].co;
         zero_d      = (g_stage[NGRP-1].acc_nxt == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_pipe_adder
// Brief    : Self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4).
// Revision : 1.0
// ============================================================================
module tb_cla_pipe_adder;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } res_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         cin_i;
   logic         op_i;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   int   n_cmp = 0;
   int   n_mis = 0;
   int   n_out = 0;
   res_t exp_q[$];
   logic snap_v = 1'b0;
   res_t snap;

   cla_pipe_adder #(
      .WIDTH (16),
      .GROUP (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .cin       (cin_i),
      .op        (op_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic reference: plain integer add/subtract and signed range check.
   function automatic res_t model(logic [W-1:0] ta, logic [W-1:0] tb, logic tc, logic top);
      res_t        r;
      int          sa, sb, sr;
      int unsigned ur;
      sa = int'($signed(ta));
      sb = int'($signed(tb));
      if (top == 1'b0) begin
         ur     = 32'(ta) + 32'(tb) + 32'(tc);
         sr     = sa + sb + int'(tc);
         r.sum  = ur[15:0];
         r.cout = ur[16];
      end else begin
         ur     = 32'(ta) - 32'(tb);
         sr     = sa - sb;
         r.sum  = ur[15:0];
         r.cout = (ta >= tb);
      end
      r.ovf  = (sr > 32767) || (sr < -32768);
      r.zero = (r.sum == 16'h0000);
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic rand_beat();
      a_i   = 16'($urandom);
      b_i   = 16'($urandom);
      cin_i = 1'($urandom);
      op_i  = 1'($urandom);
   endtask

   // Scoreboard: push on accept, compare on output handshake.
   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready)
         exp_q.push_back(model(a_i, b_i, cin_i, op_i));
   end

   always @(negedge clk) begin
      snap_v = out_valid;
      snap   = '{sum, cout, ovf, zero};
   end

   always @(posedge clk) begin
      res_t e;
      if (rst_n && snap_v && out_ready) begin
         n_out++;
         chk("sb_result_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_sum",  32'(snap.sum),  32'(e.sum));
            chk("sb_cout", 32'(snap.cout), 32'(e.cout));
            chk("sb_ovf",  32'(snap.ovf),  32'(e.ovf));
            chk("sb_zero", 32'(snap.zero), 32'(e.zero));
         end
      end
   end

   task automatic single_beat(string tag, logic [W-1:0] ta, logic [W-1:0] tb, logic tc,
                              logic top, logic [W-1:0] esum, logic ec, logic eo, logic ez);
      int lat;
      a_i      = ta;
      b_i      = tb;
      cin_i    = tc;
      op_i     = top;
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      chk({tag, "_sum"},  32'(sum),  32'(esum));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_ovf"},  32'(ovf),  32'(eo));
      chk({tag, "_zero"}, 32'(zero), 32'(ez));
      tick();
      chk({tag, "_consumed"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      int t;
      logic took;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a_i       = '0;
      b_i       = '0;
      cin_i     = 1'b0;
      op_i      = 1'b0;
      took      = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_sum",       32'(sum),       32'd0);
      chk("rst_flags",     {29'd0, cout, ovf, zero}, 32'd0);
      rst_n = 1'b1;

      // Directed beats; the first is presented on the first edge after release
      single_beat("add_basic",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
      single_beat("add_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      single_beat("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      single_beat("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      single_beat("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

      // Streaming: 20 back-to-back beats
      base = n_out;
      for (int i = 0; i < 25; i++) begin
         if (i < 20) begin
            rand_beat();
            in_valid = 1'b1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         chk("stream_out_valid", 32'(out_valid), 32'((i >= 4) && (i < 24)));
      end
      chk("stream_count", 32'(n_out - base), 32'd20);

      // Backpressure: hold outputs for 3 cycles while a result is waiting
      base = n_out;
      for (int i = 0; i < 5; i++) begin
         rand_beat();
         in_valid = 1'b1;
         tick();
      end
      chk("stall_pre_valid", 32'(out_valid), 32'd1);
      rand_beat();
      out_ready = 1'b0;
      #1;
      chk("stall_in_ready0", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid",    32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready),  32'd0);
         chk("stall_sb_depth", 32'(exp_q.size()), 32'd5);
         if (exp_q.size() != 0) begin
            chk("stall_sum",   32'(sum),  32'(exp_q[0].sum));
            chk("stall_flags", {29'd0, cout, ovf, zero},
                {29'd0, exp_q[0].cout, exp_q[0].ovf, exp_q[0].zero});
         end
      end
      out_ready = 1'b1;
      tick();
      rand_beat();
      tick();
      rand_beat();
      tick();
      in_valid = 1'b0;
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         tick();
         t++;
      end
      chk("stall_drained", 32'(exp_q.size()), 32'd0);
      chk("stall_count",   32'(n_out - base), 32'd8);

      // Random traffic with random backpressure
      in_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!in_valid || took) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rand_beat();
         end
         out_ready = ($urandom_range(0, 9) < 7);
         #1;
         took = in_valid && in_ready;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         tick();
         t++;
      end
      chk("rand_drained", 32'(exp_q.size()), 32'd0);

      // Reset with beats in flight
      a_i      = 16'h1234;
      b_i      = 16'h1111;
      cin_i    = 1'b0;
      op_i     = 1'b0;
      in_valid = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         rand_beat();
         tick();
      end
      chk("rst_mid_valid", 32'(out_valid), 32'd1);
      chk("rst_mid_sum",   32'(sum),       32'h2345);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_async_valid",    32'(out_valid), 32'd0);
      chk("rst_async_sum",      32'(sum),       32'd0);
      chk("rst_async_flags",    {29'd0, cout, ovf, zero}, 32'd0);
      chk("rst_async_in_ready", 32'(in_ready),  32'd1);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rst_no_stale", 32'(out_valid), 32'd0);
      end
      single_beat("sub_equal", 16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
